// File: rtl/fir_feeder.sv
// fir_feeder: sequences host sample and coefficient bursts into a FIR filter.
// Two-stage pipeline: stage A (kind + data) drives the filter controls and
// stage B (data only) drives x_n one cycle later. The filter's state machine
// lags its control inputs by one cycle, so the data has to trail the control.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for the first word of a burst; accepts either kind
// COEF   | coefficient burst in progress; gaps become bubbles
// STREAM | sample burst in progress; gaps become zero samples
// TURN   | one dead cycle with both controls low before returning to IDLE
module fir_feeder #(
    parameter int COEF_WORDS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] in_data,
    input  logic       in_is_coef,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] x_n,
    output logic       s_axis_fir_tvalid,
    output logic       s_set_coeffs,
    output logic       busy,
    output logic [7:0] underflow_cnt,
    output logic       coef_err
);

    localparam int CW = $clog2(COEF_WORDS + 1);

    typedef enum logic [1:0] {IDLE, COEF, STREAM, TURN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   word_cnt;

    logic            a_valid;
    logic            a_coef;
    logic [5:0]      a_data;
    logic            b_valid;
    logic [5:0]      b_data;
    logic [7:0]      uf_cnt;
    logic            err_q;

    logic            ready_raw;
    logic            accept;
    logic            load_valid;
    logic            load_coef;
    logic [5:0]      load_data;
    logic            uf_inc;
    logic            err_set;
    logic            cnt_load;
    logic            cnt_inc;

    // in_ready is forced low during reset so nothing is taken while flushing
    assign in_ready = ready_raw & ~reset;
    assign accept   = in_valid & in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_is_coef) state_nxt = (COEF_WORDS == 1) ? TURN : COEF;
                    else if (in_last) state_nxt = TURN;
                    else state_nxt = STREAM;
                end
            end
            COEF: begin
                if (accept && word_cnt == CW'(COEF_WORDS - 1)) state_nxt = TURN;
            end
            STREAM: begin
                // a coefficient word mid-stream ends the burst; it stays pending for IDLE
                if (accept && in_last) state_nxt = TURN;
                else if (in_valid && in_is_coef) state_nxt = TURN;
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / stage-A load decode
    always_comb begin
        ready_raw  = 1'b0;
        load_valid = 1'b0;
        load_coef  = 1'b0;
        load_data  = 6'd0;
        uf_inc     = 1'b0;
        err_set    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    load_valid = 1'b1;
                    load_coef  = in_is_coef;
                    load_data  = in_data;
                    cnt_load   = in_is_coef;
                end
            end
            COEF: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    load_valid = 1'b1;
                    load_coef  = 1'b1;
                    load_data  = in_data;
                    cnt_inc    = 1'b1;
                end
            end
            STREAM: begin
                ready_raw = ~in_is_coef;
                if (in_valid && !in_is_coef) begin
                    load_valid = 1'b1;
                    load_data  = in_data;
                end else if (in_valid) begin
                    err_set = 1'b1;
                end else begin
                    // zero sample keeps tvalid high so the delay line is not flushed
                    load_valid = 1'b1;
                    uf_inc     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pipeline stages, word counter, underflow counter and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid  <= 1'b0;
            a_coef   <= 1'b0;
            a_data   <= 6'd0;
            b_valid  <= 1'b0;
            b_data   <= 6'd0;
            uf_cnt   <= 8'd0;
            err_q    <= 1'b0;
            word_cnt <= '0;
        end else begin
            a_valid <= load_valid;
            a_coef  <= load_coef;
            a_data  <= load_data;
            b_valid <= a_valid;
            b_data  <= a_valid ? a_data : 6'd0;
            if (uf_inc && uf_cnt != 8'hFF) uf_cnt <= uf_cnt + 8'd1;
            if (err_set) err_q <= 1'b1;
            if (cnt_load)     word_cnt <= CW'(1);
            else if (cnt_inc) word_cnt <= word_cnt + CW'(1);
        end
    end

    assign x_n               = (b_valid && !reset) ? b_data : 6'd0;
    assign s_set_coeffs      = a_valid & a_coef & ~reset;
    assign s_axis_fir_tvalid = a_valid & ~a_coef & ~reset;
    assign busy              = ~reset & ((state != IDLE) | a_valid | b_valid);
    assign underflow_cnt     = reset ? 8'd0 : uf_cnt;
    assign coef_err          = err_q & ~reset;

endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: directed-vector bench for fir_feeder.
module tb_fir_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] in_data;
    logic       in_is_coef;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] x_n;
    logic       s_axis_fir_tvalid;
    logic       s_set_coeffs;
    logic       busy;
    logic [7:0] underflow_cnt;
    logic       coef_err;

    int n_checks = 0;
    int n_fail   = 0;

    fir_feeder #(.COEF_WORDS(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_is_coef        (in_is_coef),
        .in_last           (in_last),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .x_n               (x_n),
        .s_axis_fir_tvalid (s_axis_fir_tvalid),
        .s_set_coeffs      (s_set_coeffs),
        .busy              (busy),
        .underflow_cnt     (underflow_cnt),
        .coef_err          (coef_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic c, input logic l, input logic [5:0] d);
        in_valid   = v;
        in_is_coef = c;
        in_last    = l;
        in_data    = d;
    endtask

    logic [5:0] coefs  [3] = '{6'h24, 6'h1B, 6'h3F};
    logic [5:0] samps  [4] = '{6'h05, 6'h3D, 6'h0C, 6'h20};
    logic [5:0] uf_x   [6] = '{6'h00, 6'h00, 6'h07, 6'h00, 6'h00, 6'h09};
    logic       uf_tv  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       uf_vld [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        reset = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 6'd0);
        repeat (3) step();
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_xn", x_n, 0);
        check("rst_tvalid", s_axis_fir_tvalid, 0);
        check("rst_setc", s_set_coeffs, 0);
        check("rst_busy", busy, 0);
        check("rst_uf", underflow_cnt, 0);
        check("rst_err", coef_err, 0);

        // cycle 0: release reset
        step();
        reset = 1'b0;
        step();

        // coefficient burst, words in cycles 1-3
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drv(1'b1, 1'b1, 1'b0, coefs[i]);
            else       drv(1'b0, 1'b0, 1'b0, 6'd0);
            @(negedge clk);
            check("coef_setc", s_set_coeffs, (i >= 1 && i <= 3));
            check("coef_tvalid", s_axis_fir_tvalid, 0);
            check("coef_xn", x_n, (i >= 2 && i <= 4) ? coefs[i-2] : 6'd0);
            check("coef_ready", in_ready, (i == 3) ? 0 : 1);
            check("coef_busy", busy, (i >= 1 && i <= 4));
            step();
        end

        // sample burst 5, -3, 12, -32 (last)
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drv(1'b1, 1'b0, (i == 3), samps[i]);
            else       drv(1'b0, 1'b0, 1'b0, 6'd0);
            @(negedge clk);
            check("samp_tvalid", s_axis_fir_tvalid, (i >= 1 && i <= 4));
            check("samp_setc", s_set_coeffs, 0);
            check("samp_xn", x_n, (i >= 2 && i <= 5) ? samps[i-2] : 6'd0);
            if (i == 4) check("samp_turn_ready", in_ready, 0);
            if (i == 6) check("samp_busy_low", busy, 0);
            step();
        end

        // sample burst with two stalled cycles
        for (int i = 0; i < 6; i++) begin
            drv(uf_vld[i], 1'b0, (i == 3), (i == 0) ? 6'd7 : (i == 3) ? 6'd9 : 6'd0);
            @(negedge clk);
            check("uf_tvalid", s_axis_fir_tvalid, uf_tv[i]);
            check("uf_xn", x_n, uf_x[i]);
            if (i == 4) check("uf_turn_ready", in_ready, 0);
            step();
        end
        check("uf_count2", underflow_cnt, 2);

        // coefficient word presented mid-stream
        drv(1'b1, 1'b0, 1'b0, 6'd1);
        step();
        drv(1'b1, 1'b1, 1'b0, 6'h15);
        @(negedge clk);
        check("ce_ready_stream", in_ready, 0);
        check("ce_tvalid", s_axis_fir_tvalid, 1);
        check("ce_err_before", coef_err, 0);
        step();
        @(negedge clk);
        check("ce_err_set", coef_err, 1);
        check("ce_turn_ready", in_ready, 0);
        check("ce_turn_tvalid", s_axis_fir_tvalid, 0);
        check("ce_turn_setc", s_set_coeffs, 0);
        check("ce_turn_xn", x_n, 6'd1);
        check("ce_no_uf", underflow_cnt, 2);
        step();
        @(negedge clk);
        check("ce_idle_ready", in_ready, 1);
        check("ce_idle_tvalid", s_axis_fir_tvalid, 0);
        check("ce_idle_setc", s_set_coeffs, 0);
        step();
        drv(1'b1, 1'b1, 1'b0, 6'h2A);
        @(negedge clk);
        check("ce_burst_setc1", s_set_coeffs, 1);
        step();
        drv(1'b1, 1'b1, 1'b0, 6'h3F);
        @(negedge clk);
        check("ce_burst_xn1", x_n, 6'h15);
        step();
        drv(1'b0, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        check("ce_burst_setc3", s_set_coeffs, 1);
        check("ce_burst_xn2", x_n, 6'h2A);
        check("ce_burst_ready", in_ready, 0);
        step();
        @(negedge clk);
        check("ce_burst_xn3", x_n, 6'h3F);
        check("ce_burst_end", s_set_coeffs, 0);
        step();

        // long stall saturates the underflow counter
        drv(1'b1, 1'b0, 1'b0, 6'd4);
        step();
        drv(1'b0, 1'b0, 1'b0, 6'd0);
        repeat (100) step();
        @(negedge clk);
        check("sat_mid", underflow_cnt, 102);
        repeat (200) step();
        @(negedge clk);
        check("sat_255", underflow_cnt, 255);
        check("sat_tvalid", s_axis_fir_tvalid, 1);
        check("sat_xn_zero", x_n, 0);
        step();
        drv(1'b1, 1'b0, 1'b1, 6'd3);
        step();
        drv(1'b0, 1'b0, 1'b0, 6'd0);
        repeat (3) step();
        @(negedge clk);
        check("sat_hold", underflow_cnt, 255);
        check("sat_err_sticky", coef_err, 1);
        check("sat_idle_busy", busy, 0);

        // reset in the cycle after the second coefficient word
        step();
        drv(1'b1, 1'b1, 1'b0, 6'h01);
        step();
        drv(1'b1, 1'b1, 1'b0, 6'h02);
        step();
        reset = 1'b1;
        drv(1'b1, 1'b1, 1'b0, 6'h03);
        @(negedge clk);
        check("mr_in_ready", in_ready, 0);
        check("mr_in_setc", s_set_coeffs, 0);
        check("mr_in_xn", x_n, 0);
        check("mr_in_busy", busy, 0);
        step();
        reset = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        check("mr_ready", in_ready, 1);
        check("mr_setc", s_set_coeffs, 0);
        check("mr_tvalid", s_axis_fir_tvalid, 0);
        check("mr_xn", x_n, 0);
        check("mr_busy", busy, 0);
        check("mr_uf", underflow_cnt, 0);
        check("mr_err", coef_err, 0);
        step();
        @(negedge clk);
        check("mr_setc_after", s_set_coeffs, 0);
        check("mr_xn_after", x_n, 0);
        check("mr_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
